mem_port_arbiter: RTL and testbench

Shares the single synchronous memory bus between the instruction-fetch port and the load/store port of the five-stage core. Captures one request at a time and drives the bus until the slave acknowledges. Returns read data, or a write acknowledge, to the owning requester. Issues stall indications to the front end and to MEM, and guarantees fetch forward progress under continuous load/store traffic.

---
 rtl/mem_port_arbiter.sv | 167 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 429 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous memory bus between the fetch (IF) and load/store (LS) ports.
// Optional bus-wait timeout abort is compiled in with `define MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned LS_STREAK = 4,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic                clk,
  input  logic                rest,
  input  logic                if_req_i,
  input  logic [ADDR_W-1:0]   if_addr_i,
  output logic                if_gnt_o,
  output logic                if_rvalid_o,
  output logic [DATA_W-1:0]   if_rdata_o,
  input  logic                ls_req_i,
  input  logic                ls_we_i,
  input  logic [ADDR_W-1:0]   ls_addr_i,
  input  logic [DATA_W-1:0]   ls_wdata_i,
  input  logic [DATA_W/8-1:0] ls_be_i,
  output logic                ls_gnt_o,
  output logic                ls_rvalid_o,
  output logic [DATA_W-1:0]   ls_rdata_o,
  output logic                bus_req_o,
  output logic                bus_we_o,
  output logic [ADDR_W-1:0]   bus_addr_o,
  output logic [DATA_W-1:0]   bus_wdata_o,
  output logic [DATA_W/8-1:0] bus_be_o,
  input  logic                bus_ready_i,
  input  logic [DATA_W-1:0]   bus_rdata_i,
  output logic                stall_if_o,
  output logic                stall_ls_o,
  output logic                bus_err_o
);

  typedef enum logic [1:0] {StIdle, StBusyIf, StBusyLs} state_e;

  state_e r_state, w_state_d;
  logic [3:0] r_streak, w_streak_d;

  logic                r_bus_req, r_bus_we;
  logic [ADDR_W-1:0]   r_bus_addr;
  logic [DATA_W-1:0]   r_bus_wdata;
  logic [DATA_W/8-1:0] r_bus_be;
  logic                r_if_rvalid, r_ls_rvalid, r_err;
  logic [DATA_W-1:0]   r_if_rdata, r_ls_rdata;

  logic w_busy, w_done, w_abort, w_fin, w_arb, w_if_pri, w_if_gnt, w_ls_gnt;

  assign w_busy = (r_state != StIdle);
  assign w_done = w_busy & bus_ready_i;
  assign w_fin  = w_done | w_abort;

`ifdef MEM_ARB_TIMEOUT_EN
  logic [7:0] r_tmo;

  // Abort on the TIMEOUT-th consecutive wait cycle; pulses appear the cycle after.
  assign w_abort = w_busy & ~bus_ready_i & (r_tmo == 8'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      r_tmo <= 8'd0;
    end else if (w_if_gnt || w_ls_gnt || w_abort) begin
      r_tmo <= 8'd0;
    end else if (w_busy && !bus_ready_i) begin
      r_tmo <= r_tmo + 8'd1;
    end
  end
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT == 0);
  assign w_abort          = 1'b0;
`endif

  // Grants are gated by reset so every output reads 0 while rest is low.
  assign w_arb    = rest & (~w_busy | w_done);
  assign w_if_pri = if_req_i & (r_streak == 4'(LS_STREAK));
  assign w_ls_gnt = w_arb & ls_req_i & ~w_if_pri;
  assign w_if_gnt = w_arb & if_req_i & ~w_ls_gnt;

  always_comb begin
    w_state_d  = r_state;
    w_streak_d = r_streak;
    if (w_ls_gnt) begin
      w_state_d = StBusyLs;
    end else if (w_if_gnt) begin
      w_state_d = StBusyIf;
    end else if (w_fin) begin
      w_state_d = StIdle;
    end
    if (w_if_gnt || !if_req_i) begin
      w_streak_d = 4'd0;
    end else if (w_ls_gnt && (r_streak < 4'(LS_STREAK))) begin
      w_streak_d = r_streak + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      r_state  <= StIdle;
      r_streak <= 4'd0;
    end else begin
      r_state  <= w_state_d;
      r_streak <= w_streak_d;
    end
  end

  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_wdata <= '0;
      r_bus_be    <= '0;
    end else if (w_ls_gnt) begin
      r_bus_req   <= 1'b1;
      r_bus_we    <= ls_we_i;
      r_bus_addr  <= ls_addr_i;
      r_bus_wdata <= ls_wdata_i;
      r_bus_be    <= ls_be_i;
    end else if (w_if_gnt) begin
      r_bus_req   <= 1'b1;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= if_addr_i;
      r_bus_wdata <= '0;
      r_bus_be    <= '1;
    end else if (w_fin) begin
      r_bus_req <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      r_if_rvalid <= 1'b0;
      r_ls_rvalid <= 1'b0;
      r_if_rdata  <= '0;
      r_ls_rdata  <= '0;
      r_err       <= 1'b0;
    end else begin
      r_if_rvalid <= w_fin & (r_state == StBusyIf);
      r_ls_rvalid <= w_fin & (r_state == StBusyLs);
      r_err       <= w_abort;
      if (w_fin && (r_state == StBusyIf)) begin
        r_if_rdata <= w_abort ? '0 : bus_rdata_i;
      end
      if (w_fin && (r_state == StBusyLs)) begin
        r_ls_rdata <= (w_abort || r_bus_we) ? '0 : bus_rdata_i;
      end
    end
  end

  assign if_gnt_o    = w_if_gnt;
  assign ls_gnt_o    = w_ls_gnt;
  assign stall_if_o  = rest & if_req_i & ~w_if_gnt;
  assign stall_ls_o  = rest & ls_req_i & ~w_ls_gnt;
  assign if_rvalid_o = r_if_rvalid;
  assign if_rdata_o  = r_if_rdata;
  assign ls_rvalid_o = r_ls_rvalid;
  assign ls_rdata_o  = r_ls_rdata;
  assign bus_req_o   = r_bus_req;
  assign bus_we_o    = r_bus_we;
  assign bus_addr_o  = r_bus_addr;
  assign bus_wdata_o = r_bus_wdata;
  assign bus_be_o    = r_bus_be;
  assign bus_err_o   = r_err;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a randomized run
// against a transaction-level reference model.
module tb_mem_port_arbiter;
  localparam int AW     = 32;
  localparam int DW     = 32;
  localparam int STREAK = 4;
  localparam int TMO    = 8;
`ifdef MEM_ARB_TIMEOUT_EN
  localparam int WAIT_CYC = TMO - 1;
`else
  localparam int WAIT_CYC = 10;
`endif

  logic          clk = 1'b0;
  logic          rest = 1'b0;
  logic          if_req, ls_req, ls_we, bus_ready;
  logic [AW-1:0] if_addr, ls_addr;
  logic [DW-1:0] ls_wdata, bus_rdata;
  logic [3:0]    ls_be;
  logic          if_gnt_o, if_rvalid_o, ls_gnt_o, ls_rvalid_o;
  logic [DW-1:0] if_rdata_o, ls_rdata_o, bus_wdata_o;
  logic          bus_req_o, bus_we_o, stall_if_o, stall_ls_o, bus_err_o;
  logic [AW-1:0] bus_addr_o;
  logic [3:0]    bus_be_o;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .LS_STREAK(STREAK), .TIMEOUT(TMO)
  ) u_dut (
    .clk(clk), .rest(rest),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .ls_req_i(ls_req), .ls_we_i(ls_we), .ls_addr_i(ls_addr), .ls_wdata_i(ls_wdata),
    .ls_be_i(ls_be), .ls_gnt_o(ls_gnt_o), .ls_rvalid_o(ls_rvalid_o), .ls_rdata_o(ls_rdata_o),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
    .bus_wdata_o(bus_wdata_o), .bus_be_o(bus_be_o), .bus_ready_i(bus_ready),
    .bus_rdata_i(bus_rdata), .stall_if_o(stall_if_o), .stall_ls_o(stall_ls_o),
    .bus_err_o(bus_err_o)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    if_req = 1'b0; if_addr = '0; ls_req = 1'b0; ls_we = 1'b0; ls_addr = '0;
    ls_wdata = '0; ls_be = '0; bus_ready = 1'b0; bus_rdata = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rest = 1'b0;
    sample();
    n_chk++;
    if ({bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_be_o, if_rvalid_o, ls_rvalid_o,
         if_rdata_o, ls_rdata_o, bus_err_o, if_gnt_o, ls_gnt_o} !== '0)
      $display("FAIL reset_outputs: got bus_req=%b addr=%h rv=%b%b err=%b, want all 0",
               bus_req_o, bus_addr_o, if_rvalid_o, ls_rvalid_o, bus_err_o);
    else n_pass++;
    step();
    rest = 1'b1;
    sample();
    n_chk++;
    if (bus_req_o !== 1'b0) $display("FAIL reset_release_idle: got %b want 0", bus_req_o);
    else n_pass++;
  endtask

  task automatic test_if_read();
    step();
    if_req = 1'b1; if_addr = 32'h100;
    sample();
    n_chk++;
    if ({if_gnt_o, ls_gnt_o, stall_if_o, bus_req_o} !== 4'b1000)
      $display("FAIL ifrd_c0_gnt: got gnt/lsgnt/stall/req=%b want 1000",
               {if_gnt_o, ls_gnt_o, stall_if_o, bus_req_o});
    else n_pass++;
    step();
    if_req = 1'b0; bus_ready = 1'b1; bus_rdata = 32'hDEADBEEF;
    sample();
    n_chk++;
    if ({bus_req_o, bus_we_o, bus_addr_o, bus_be_o} !== {2'b10, 32'h100, 4'hF})
      $display("FAIL ifrd_c1_bus: got req=%b we=%b addr=%h be=%h want 1 0 100 f",
               bus_req_o, bus_we_o, bus_addr_o, bus_be_o);
    else n_pass++;
    n_chk++;
    if (if_rvalid_o !== 1'b0) $display("FAIL ifrd_c1_rvalid: got %b want 0", if_rvalid_o);
    else n_pass++;
    step();
    bus_ready = 1'b0; bus_rdata = '0;
    sample();
    n_chk++;
    if ({if_rvalid_o, if_rdata_o, bus_req_o} !== {1'b1, 32'hDEADBEEF, 1'b0})
      $display("FAIL ifrd_c2_rvalid: got rv=%b data=%h req=%b want 1 deadbeef 0",
               if_rvalid_o, if_rdata_o, bus_req_o);
    else n_pass++;
    step();
    sample();
    n_chk++;
    if ({if_rvalid_o, if_rdata_o} !== {1'b0, 32'hDEADBEEF})
      $display("FAIL ifrd_c3_hold: got rv=%b data=%h want 0 deadbeef", if_rvalid_o, if_rdata_o);
    else n_pass++;
  endtask

  task automatic test_store_then_if();
    step();
    if_req = 1'b1; if_addr = 32'h300;
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h200; ls_wdata = 32'h12345678; ls_be = 4'hF;
    sample();
    n_chk++;
    if ({ls_gnt_o, if_gnt_o, stall_if_o, stall_ls_o} !== 4'b1010)
      $display("FAIL st_c0_gnt: got lsgnt/ifgnt/stif/stls=%b want 1010",
               {ls_gnt_o, if_gnt_o, stall_if_o, stall_ls_o});
    else n_pass++;
    step();
    ls_req = 1'b0; bus_ready = 1'b1; bus_rdata = 32'hAAAA5555;
    sample();
    n_chk++;
    if ({bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_be_o} !==
        {2'b11, 32'h200, 32'h12345678, 4'hF})
      $display("FAIL st_c1_bus: got req=%b we=%b addr=%h wd=%h be=%h want 1 1 200 12345678 f",
               bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_be_o);
    else n_pass++;
    n_chk++;
    if (if_gnt_o !== 1'b1) $display("FAIL st_c1_if_gnt: got %b want 1", if_gnt_o);
    else n_pass++;
    step();
    if_req = 1'b0; bus_rdata = 32'hCAFEF00D;
    sample();
    n_chk++;
    if ({ls_rvalid_o, ls_rdata_o, bus_we_o, bus_addr_o} !== {1'b1, 32'h0, 1'b0, 32'h300})
      $display("FAIL st_c2_ack: got rv=%b data=%h we=%b addr=%h want 1 0 0 300",
               ls_rvalid_o, ls_rdata_o, bus_we_o, bus_addr_o);
    else n_pass++;
    step();
    bus_ready = 1'b0;
    sample();
    n_chk++;
    if ({if_rvalid_o, if_rdata_o, ls_rvalid_o, bus_req_o} !== {1'b1, 32'hCAFEF00D, 2'b00})
      $display("FAIL st_c3_if: got rv=%b data=%h lsrv=%b req=%b want 1 cafef00d 0 0",
               if_rvalid_o, if_rdata_o, ls_rvalid_o, bus_req_o);
    else n_pass++;
  endtask

  task automatic test_streak();
    logic exp_if;
    step();
    if_req = 1'b1; if_addr = 32'h600;
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h700; ls_be = 4'hF;
    bus_ready = 1'b1; bus_rdata = 32'h0;
    for (int k = 0; k < 3 * (STREAK + 1); k++) begin
      sample();
      exp_if = ((k % (STREAK + 1)) == STREAK);
      n_chk++;
      if ({if_gnt_o, ls_gnt_o, stall_if_o} !== {exp_if, !exp_if, !exp_if})
        $display("FAIL streak_k%0d: got ifgnt/lsgnt/stif=%b want %b", k,
                 {if_gnt_o, ls_gnt_o, stall_if_o}, {exp_if, !exp_if, !exp_if});
      else n_pass++;
      step();
    end
    if_req = 1'b0; ls_req = 1'b0;
    step();
    step();
    bus_ready = 1'b0;
  endtask

  task automatic test_wait_stable();
    step();
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h400; ls_be = 4'h3; ls_wdata = '0;
    bus_ready = 1'b0;
    sample();
    n_chk++;
    if (ls_gnt_o !== 1'b1) $display("FAIL wait_gnt: got %b want 1", ls_gnt_o);
    else n_pass++;
    step();
    ls_req = 1'b0; ls_addr = 32'hFFFF_FFFF; ls_be = 4'h0;
    for (int i = 0; i < WAIT_CYC; i++) begin
      sample();
      n_chk++;
      if ({bus_req_o, bus_we_o, bus_addr_o, bus_be_o, ls_rvalid_o} !==
          {2'b10, 32'h400, 4'h3, 1'b0})
        $display("FAIL wait_stable_%0d: got req=%b we=%b addr=%h be=%h rv=%b want 1 0 400 3 0",
                 i, bus_req_o, bus_we_o, bus_addr_o, bus_be_o, ls_rvalid_o);
      else n_pass++;
      step();
    end
    bus_ready = 1'b1; bus_rdata = 32'h55AA33CC;
    step();
    bus_ready = 1'b0; bus_rdata = '0;
    sample();
    n_chk++;
    if ({ls_rvalid_o, ls_rdata_o} !== {1'b1, 32'h55AA33CC})
      $display("FAIL wait_rvalid: got rv=%b data=%h want 1 55aa33cc", ls_rvalid_o, ls_rdata_o);
    else n_pass++;
    step();
    sample();
    n_chk++;
    if (ls_rvalid_o !== 1'b0) $display("FAIL wait_single_pulse: got %b want 0", ls_rvalid_o);
    else n_pass++;
  endtask

  task automatic test_timeout();
    step();
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h800; ls_be = 4'hF; bus_ready = 1'b0;
    sample();
    n_chk++;
    if (ls_gnt_o !== 1'b1) $display("FAIL tmo_gnt: got %b want 1", ls_gnt_o);
    else n_pass++;
    step();
    ls_req = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
    for (int i = 0; i < TMO; i++) begin
      sample();
      n_chk++;
      if ({bus_req_o, bus_err_o, ls_rvalid_o} !== 3'b100)
        $display("FAIL tmo_wait_%0d: got req/err/rv=%b want 100", i,
                 {bus_req_o, bus_err_o, ls_rvalid_o});
      else n_pass++;
      step();
    end
    sample();
    n_chk++;
    if ({bus_err_o, ls_rvalid_o, ls_rdata_o, bus_req_o} !== {2'b11, 32'h0, 1'b0})
      $display("FAIL tmo_abort: got err=%b rv=%b data=%h req=%b want 1 1 0 0",
               bus_err_o, ls_rvalid_o, ls_rdata_o, bus_req_o);
    else n_pass++;
    step();
    sample();
    n_chk++;
    if ({bus_err_o, ls_rvalid_o, bus_req_o} !== 3'b000)
      $display("FAIL tmo_after: got err/rv/req=%b want 000", {bus_err_o, ls_rvalid_o, bus_req_o});
    else n_pass++;
`else
    for (int i = 0; i < 3 * TMO; i++) begin
      sample();
      n_chk++;
      if ({bus_req_o, bus_err_o, ls_rvalid_o} !== 3'b100)
        $display("FAIL notmo_wait_%0d: got req/err/rv=%b want 100", i,
                 {bus_req_o, bus_err_o, ls_rvalid_o});
      else n_pass++;
      step();
    end
    bus_ready = 1'b1; bus_rdata = 32'h0BADF00D;
    step();
    bus_ready = 1'b0;
    sample();
    n_chk++;
    if ({ls_rvalid_o, ls_rdata_o, bus_err_o} !== {1'b1, 32'h0BADF00D, 1'b0})
      $display("FAIL notmo_done: got rv=%b data=%h err=%b want 1 0badf00d 0",
               ls_rvalid_o, ls_rdata_o, bus_err_o);
    else n_pass++;
`endif
  endtask

  task automatic test_reset_mid();
    step();
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h900; ls_be = 4'hF; bus_ready = 1'b0;
    sample();
    n_chk++;
    if (ls_gnt_o !== 1'b1) $display("FAIL rmid_gnt: got %b want 1", ls_gnt_o);
    else n_pass++;
    step();
    ls_req = 1'b0;
    step();
    step();
    #2;
    rest = 1'b0;
    #1;
    n_chk++;
    if ({bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_be_o, if_rvalid_o, ls_rvalid_o,
         if_rdata_o, ls_rdata_o, bus_err_o, if_gnt_o, ls_gnt_o, stall_if_o, stall_ls_o} !== '0)
      $display("FAIL rmid_async: got req=%b addr=%h ifd=%h lsd=%h want all 0",
               bus_req_o, bus_addr_o, if_rdata_o, ls_rdata_o);
    else n_pass++;
    bus_ready = 1'b1; bus_rdata = 32'h13572468;
    step();
    rest = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sample();
      n_chk++;
      if ({bus_req_o, ls_rvalid_o, if_rvalid_o} !== 3'b000)
        $display("FAIL rmid_no_rvalid_%0d: got req/lsrv/ifrv=%b want 000", i,
                 {bus_req_o, ls_rvalid_o, if_rvalid_o});
      else n_pass++;
      step();
    end
    bus_ready = 1'b0;
    if_req = 1'b1; if_addr = 32'h500;
    sample();
    n_chk++;
    if (if_gnt_o !== 1'b1) $display("FAIL rmid_if_gnt: got %b want 1", if_gnt_o);
    else n_pass++;
    step();
    if_req = 1'b0; bus_ready = 1'b1; bus_rdata = 32'h600DCAFE;
    sample();
    n_chk++;
    if ({bus_req_o, bus_addr_o} !== {1'b1, 32'h500})
      $display("FAIL rmid_if_bus: got req=%b addr=%h want 1 500", bus_req_o, bus_addr_o);
    else n_pass++;
    step();
    bus_ready = 1'b0;
    sample();
    n_chk++;
    if ({if_rvalid_o, if_rdata_o} !== {1'b1, 32'h600DCAFE})
      $display("FAIL rmid_if_rvalid: got rv=%b data=%h want 1 600dcafe", if_rvalid_o, if_rdata_o);
    else n_pass++;
  endtask

  // Reference model: one outstanding command, LS priority unless IF has waited through
  // STREAK consecutive LS grants; responses appear one cycle after the completing cycle.
  task automatic test_random();
    logic          m_busy = 1'b0, c_if = 1'b0, c_we = 1'b0;
    logic [AW-1:0] c_addr = '0;
    logic [DW-1:0] c_wdata = '0;
    logic [3:0]    c_be = '0;
    int            m_streak = 0;
    int            wait_n = 0;
    logic          m_if_rv = 1'b0, m_ls_rv = 1'b0;
    logic [DW-1:0] m_if_rd = 32'h600DCAFE, m_ls_rd = '0;
    logic          arb, e_if, e_ls;
    step();
    if_req = 1'b1; if_addr = $urandom;
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = $urandom; ls_wdata = $urandom; ls_be = 4'hF;
    bus_ready = 1'b0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      sample();
      arb  = !m_busy || bus_ready;
      e_ls = arb && ls_req && !(if_req && (m_streak == STREAK));
      e_if = arb && if_req && !e_ls;
      n_chk++;
      if ({if_gnt_o, ls_gnt_o, stall_if_o, stall_ls_o} !==
          {e_if, e_ls, if_req && !e_if, ls_req && !e_ls})
        $display("FAIL rnd_gnt_%0d: got ifg/lsg/stif/stls=%b want %b", cyc,
                 {if_gnt_o, ls_gnt_o, stall_if_o, stall_ls_o},
                 {e_if, e_ls, if_req && !e_if, ls_req && !e_ls});
      else n_pass++;
      n_chk++;
      if (bus_req_o !== m_busy) $display("FAIL rnd_busreq_%0d: got %b want %b", cyc,
                                         bus_req_o, m_busy);
      else n_pass++;
      if (m_busy) begin
        n_chk++;
        if ({bus_we_o, bus_addr_o, bus_be_o} !== {c_we, c_addr, c_be})
          $display("FAIL rnd_cmd_%0d: got we=%b addr=%h be=%h want %b %h %h", cyc,
                   bus_we_o, bus_addr_o, bus_be_o, c_we, c_addr, c_be);
        else n_pass++;
        if (c_we) begin
          n_chk++;
          if (bus_wdata_o !== c_wdata)
            $display("FAIL rnd_wdata_%0d: got %h want %h", cyc, bus_wdata_o, c_wdata);
          else n_pass++;
        end
      end
      n_chk++;
      if ({if_rvalid_o, if_rdata_o, ls_rvalid_o, ls_rdata_o, bus_err_o} !==
          {m_if_rv, m_if_rd, m_ls_rv, m_ls_rd, 1'b0})
        $display("FAIL rnd_resp_%0d: got ifrv=%b ifd=%h lsrv=%b lsd=%h err=%b want %b %h %b %h 0",
                 cyc, if_rvalid_o, if_rdata_o, ls_rvalid_o, ls_rdata_o, bus_err_o,
                 m_if_rv, m_if_rd, m_ls_rv, m_ls_rd);
      else n_pass++;
      m_if_rv = 1'b0;
      m_ls_rv = 1'b0;
      if (m_busy && bus_ready) begin
        if (c_if) begin
          m_if_rv = 1'b1; m_if_rd = bus_rdata;
        end else begin
          m_ls_rv = 1'b1; m_ls_rd = c_we ? '0 : bus_rdata;
        end
        m_busy = 1'b0;
      end
      if (e_ls) begin
        m_busy = 1'b1; c_if = 1'b0; c_we = ls_we; c_addr = ls_addr;
        c_wdata = ls_wdata; c_be = ls_be;
      end else if (e_if) begin
        m_busy = 1'b1; c_if = 1'b1; c_we = 1'b0; c_addr = if_addr; c_be = 4'hF;
      end
      if (e_if || !if_req) m_streak = 0;
      else if (e_ls && m_streak < STREAK) m_streak++;
      step();
      if (!if_req || e_if) begin
        if_req = ($urandom_range(0, 3) != 0); if_addr = $urandom;
      end
      if (!ls_req || e_ls) begin
        ls_req = ($urandom_range(0, 3) != 0); ls_we = 1'($urandom_range(0, 1));
        ls_addr = $urandom; ls_wdata = $urandom; ls_be = 4'($urandom_range(0, 15));
      end
      if (!m_busy) wait_n = 0;
      bus_ready = (wait_n >= 4) ? 1'b1 : ($urandom_range(0, 2) != 0);
      if (m_busy && !bus_ready) wait_n++;
      else wait_n = 0;
      bus_rdata = $urandom;
    end
    if_req = 1'b0; ls_req = 1'b0; bus_ready = 1'b1;
    step();
    step();
    sample();
    n_chk++;
    if (bus_req_o !== 1'b0) $display("FAIL rnd_drain: got %b want 0", bus_req_o);
    else n_pass++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_if_read();
    test_store_then_if();
    test_streak();
    test_wait_stable();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
